// File: rtl/rv32_pkg.sv
// Shared RV32I front-end definitions: constants and the fetch buffer entry type.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_e;

endpackage

// File: rtl/ifetch_skid_buf.sv
// Two-entry FIFO between fetch and decode; head entry is presented straight from storage.
module ifetch_skid_buf
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    localparam fetch_entry_t RESET_ENTRY = '{instr: NOP_INSTR, pc: '0, fault: 1'b0};

    fetch_entry_t r_mem [DEPTH];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_ENTRY;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            // When full, push and pop share a slot: the popped head is overwritten at the same edge.
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: PC, imem addressing, redirect handling and decode-side skid buffer.
// Optional misaligned-target fault reporting is enabled by defining IFETCH_MISALIGN_FAULT_EN.
module ifetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_fault
);

    logic [31:0]  r_pc;
    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_data;
    logic         w_pop;
    logic         w_cap;
    logic         w_run;
    logic         w_fault;
    logic [31:0]  w_redir_pc;

`ifdef IFETCH_MISALIGN_FAULT_EN
    fetch_state_e r_state;

    // A faulting capture parks fetch until execute redirects it elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_RUN;
        end else if (redirect_valid) begin
            r_state <= FETCH_RUN;
        end else begin
            case (r_state)
                FETCH_RUN:  if (w_cap && w_fault) r_state <= FETCH_HALT;
                FETCH_HALT: r_state <= FETCH_HALT;
                default:    r_state <= FETCH_RUN;
            endcase
        end
    end

    assign w_run       = (r_state == FETCH_RUN);
    assign w_fault     = (r_pc[1:0] != 2'b00);
    assign w_redir_pc  = redirect_pc;
    assign fetch_fault = w_head.fault;
`else
    assign w_run       = 1'b1;
    assign w_fault     = 1'b0;
    assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
    // Entries are always pushed with fault clear, so this is constant 0.
    assign fetch_fault = w_head.fault;
`endif

    assign w_pop       = if_valid && id_ready;
    assign w_cap       = !redirect_valid && w_run && ((w_count < 2'd2) || w_pop);
    assign w_push_data = '{instr: imem_instr, pc: r_pc, fault: w_fault};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redir_pc;
        end else if (w_cap) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    ifetch_skid_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_cap),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign imem_addr = r_pc;
    assign if_valid  = (w_count != 2'd0);
    assign if_instr  = w_head.instr;
    assign if_pc     = w_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, mid-stream reset and random traffic vs a queue model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Program image: word i is "addi x_i, x_(i-2), i" for the low 128 bytes, a hash of the address elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [4:0] idx;
        logic [4:0] rs1;
        idx = addr[6:2];
        rs1 = (idx >= 5'd2) ? idx - 5'd2 : 5'd0;
        if (addr < 32'd128) return {7'b0, idx, rs1, 3'b000, idx, 7'h13};
        return addr ^ 32'h5A5A_5A5A;
    endfunction

    assign imem_instr = word_at(imem_addr);

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fetch_fault    (fetch_fault)
    );

`ifdef IFETCH_MISALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    // Reference model: queue of fetched entries plus a PC and halt flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] mpc;
    bit          mhalt;

    task automatic model_reset();
        mq.delete();
        mpc   = 32'h0;
        mhalt = 1'b0;
    endtask

    task automatic model_update();
        ment_t e;
        if (redirect_valid) begin
            mq.delete();
            mpc   = FAULT_EN ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
            mhalt = 1'b0;
        end else begin
            if (mq.size() != 0 && id_ready) void'(mq.pop_front());
            if (mq.size() < 2 && !mhalt) begin
                e.pc    = mpc;
                e.instr = word_at(mpc);
                e.fault = FAULT_EN && (mpc[1:0] != 2'b00);
                mq.push_back(e);
                mpc = mpc + 32'd4;
                if (e.fault) mhalt = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, mq.size() != 0});
        chk({tag, " imem_addr"}, imem_addr, mpc);
        if (mq.size() != 0) begin
            chk({tag, " if_pc"}, if_pc, mq[0].pc);
            chk({tag, " if_instr"}, if_instr, mq[0].instr);
            chk({tag, " fetch_fault"}, {31'b0, fetch_fault}, {31'b0, mq[0].fault});
        end
    endtask

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
        bit          efault;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit rdy, input bit rv, input logic [31:0] rpc, input bit ev,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic [31:0] eaddr, input bit efault);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
        v.epc = epc; v.einstr = einstr; v.eaddr = eaddr; v.efault = efault;
        return v;
    endfunction

    initial begin
        // Each row: inputs before an edge, outputs expected after it.
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h00, 32'h0000_0013, 32'h04, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h04, 32'h0010_0093, 32'h08, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h08, 32'h0020_0113, 32'h0C, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h08, 32'h0020_0113, 32'h10, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h08, 32'h0020_0113, 32'h10, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h08, 32'h0020_0113, 32'h10, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h0C, 32'h0030_8193, 32'h14, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h10, 32'h0041_0213, 32'h18, 0));
        vt.push_back(mk(0, 1, 32'h28, 0, 32'h0,  32'h0,         32'h28, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h28, 32'h00A4_0513, 32'h2C, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h2C, 32'h00B4_8593, 32'h30, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h2C, 32'h00B4_8593, 32'h34, 0));
        vt.push_back(mk(1, 1, 32'h3C, 0, 32'h0,  32'h0,         32'h3C, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h3C, 32'h00F6_8793, 32'h40, 0));
        vt.push_back(mk(1, 0, 32'h0,  1, 32'h40, 32'h0107_0813, 32'h44, 0));
`ifdef IFETCH_MISALIGN_FAULT_EN
        vt.push_back(mk(0, 1, 32'h05, 0, 32'h0,  32'h0,         32'h05, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h05, 32'h0010_0093, 32'h09, 1));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h05, 32'h0010_0093, 32'h09, 1));
`else
        vt.push_back(mk(0, 1, 32'h05, 0, 32'h0,  32'h0,         32'h04, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h04, 32'h0010_0093, 32'h08, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 32'h04, 32'h0010_0093, 32'h0C, 0));
`endif
        vt.push_back(mk(0, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0, 32'hFFFF_FFF8, 0));
        vt.push_back(mk(1, 0, 32'h0, 1, 32'hFFFF_FFF8, 32'hA5A5_A5A2, 32'hFFFF_FFFC, 0));
        vt.push_back(mk(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hA5A5_A5A6, 32'h0000_0000, 0));
        vt.push_back(mk(1, 0, 32'h0, 1, 32'h0000_0000, 32'h0000_0013, 32'h0000_0004, 0));

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset if_valid", {31'b0, if_valid}, 32'h0);
        chk("reset if_instr", if_instr, 32'h0000_0013);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset fetch_fault", {31'b0, fetch_fault}, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);

        rst_n = 1'b1;
        model_reset();
        chk("release imem_addr", imem_addr, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            id_ready       = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            step();
            chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].eaddr);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d if_pc", i), if_pc, vt[i].epc);
                chk($sformatf("vec%0d if_instr", i), if_instr, vt[i].einstr);
                chk($sformatf("vec%0d fetch_fault", i), {31'b0, fetch_fault}, {31'b0, vt[i].efault});
            end
        end

        // Fill the buffer, then assert reset between edges
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) step();
        chk_model("prefill");
        chk("prefill if_valid", {31'b0, if_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("async rst imem_addr", imem_addr, 32'h0);
        chk("async rst if_pc", if_pc, 32'h0);
        chk("async rst if_instr", if_instr, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        id_ready = 1'b1;
        step();
        chk("rerelease if_valid", {31'b0, if_valid}, 32'h1);
        chk("rerelease if_pc", if_pc, 32'h0);
        chk("rerelease imem_addr", imem_addr, 32'h4);

        // Random traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            int unsigned sel;
            id_ready       = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 10) == 0;
            sel = $urandom % 8;
            if (sel < 5)       redirect_pc = {$urandom_range(0, 40), 2'b00};
            else if (sel == 5) redirect_pc = $urandom_range(0, 160);
            else if (sel == 6) redirect_pc = 32'hFFFF_FFF0 + ($urandom % 16);
            else               redirect_pc = $urandom;
            step();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the RV32I core, placed directly upstream of `imem`. It owns the program counter, drives the byte address into `imem`, and captures each returned word together with its PC into a 2-entry skid buffer. The buffer feeds decode over a valid/ready handshake. Branch and jump redirects from execute flush in-flight fetches and restart the stream at the target.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `BUF_DEPTH`, 2: skid buffer entries. Fixed at 2; other values are unsupported.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `imem_addr`, output, 32: byte address to `imem`, always equal to the `pc` register.
- `imem_instr`, input, 32: combinational instruction word from `imem`, valid in the same cycle as `imem_addr`.
- `redirect_valid`, input, 1: execute requests a PC change this cycle.
- `redirect_pc`, input, 32: target byte address.
- `if_valid`, output, 1: the head buffer entry is valid for decode.
- `if_instr`, output, 32: head entry instruction.
- `if_pc`, output, 32: head entry PC.
- `id_ready`, input, 1: decode accepts the head entry when `if_valid && id_ready`.
- `fetch_fault`, output, 1: the head entry carries a misaligned-target fault. Present only with the configuration macro defined; otherwise tied to 0.

## Operation
- State:
  - `pc`, 32 bits.
  - Buffer holding 2 entries of {instr, pc, fault}.
  - Read pointer, write pointer and `count`, each 0..2.
- Events evaluated every cycle:
  - `pop` = `if_valid && id_ready`.
  - `cap` = `(count < 2) || pop`, i.e. there is space, counting the slot a same-cycle pop frees.
- Normal cycle (no redirect):
  - If `cap`: write {`imem_instr`, `pc`, 0} at the write pointer and set `pc <= pc + 4`.
  - If not `cap`: `pc` holds and `imem_addr` is stable, so no word is lost.
  - `count` updates as +1 / -1 / 0 according to `cap` and `pop`.
- Redirect cycle: `redirect_valid` has priority over every other event.
  - Drop all buffer entries: `count <= 0`, pointers reset.
  - Discard the current `imem_instr`; no capture occurs.
  - `pc <= redirect_pc` (misalignment handling: see Configuration).
  - A same-cycle `pop` still completes at decode. Decode owns squashing that instruction.
- Pointers advance modulo 2.
- The PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No fault is raised on wrap.
- `if_valid = (count != 0)`. Outputs come straight from the head entry register, so there is no combinational path from `id_ready` to `if_*`.

## Timing
- Reset values (`rst_n` low): `pc = RESET_PC`, `count = 0`, `if_valid = 0`, `if_instr = 32'h0000_0013` (NOP), `if_pc = 0`, `fetch_fault = 0`.
- First cycle after reset release: `imem_addr = RESET_PC`. The word is captured at that edge, so `if_valid` rises 1 cycle after release.
- Fetch-to-decode latency: 1 cycle with an empty buffer.
- Throughput: 1 instruction per cycle when `id_ready` is held high.
- Decode stall:
  - The buffer fills after 2 captures.
  - `pc` then freezes at (last captured PC + 4).
  - Fetch resumes in the same cycle that `id_ready` returns.
- Redirect timing:
  - Asserted in cycle N: `if_valid = 0` in cycle N+1 and `imem_addr = redirect_pc` in N+1.
  - The first target instruction is valid in N+2.
  - Redirect penalty: 2 cycles.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous). Buffered entries are lost.

## Configuration
- `IFETCH_MISALIGN_FAULT_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` loads `pc <= redirect_pc` unmodified.
  - The next capture stores fault = 1. Fetch then halts: no further captures and `pc` holds until the next redirect.
  - `fetch_fault` mirrors the head entry's fault bit.
- Not defined:
  - `pc <= {redirect_pc[31:2], 2'b00}` (low bits silently cleared).
  - `fetch_fault` is tied to 0 and the fault bit is not stored.

## Structure
- Shared package `rv32_pkg` holds the `NOP_INSTR` (32'h0000_0013) and `PC_STEP` (4) constants, plus a `fetch_entry_t` typedef {instr[31:0], pc[31:0], fault}.
- Sub-module `ifetch_skid_buf` is the 2-entry FIFO: push, pop, flush, count, head outputs. The top level contains the PC logic, the redirect priority and the fault logic.

## Test plan
- Reset release with `imem` loaded from `program.hex`, `id_ready` = 1:
  - Decode sees (pc, instr) = (0, 00000013), (4, 00100093), (8, 00200113), (C, 00308193) on consecutive cycles.
  - The first `if_valid` occurs 1 cycle after release.
- Stall:
  - Drop `id_ready` after PC 4 is accepted. `count` reaches 2 (PCs 8 and C) and `imem_addr` holds at 0x10 while stalled.
  - Raise `id_ready`: 0x08, 0x0C, 0x10 (00410213) follow with no gaps and no duplicates.
- Redirect to 0x28 while the buffer is full:
  - Next cycle `if_valid` = 0.
  - Following cycle: `if_pc` = 0x28, `if_instr` = 00a40513; then 0x2C.
- Redirect and pop in the same cycle: the popped entry completes and all other entries vanish. The redirect to 0x3C delivers 00f68793 2 cycles later.
- Misaligned redirect to 0x05:
  - With the macro defined: the head entry has `fetch_fault` = 1 and fetch halts.
  - Without it: `if_pc` = 0x04, `if_instr` = 00100093.
- Assert `rst_n` low mid-stream with `count` = 2: `if_valid` is 0 immediately and `imem_addr` = `RESET_PC`.
